// File: rtl/shapool_pkg.sv
// Shared constants and the receiver state encoding for the SHA pool job path.
package shapool_pkg;
  localparam int JOB_WIDTH_DEFAULT = 352;
  localparam int MIDSTATE_WIDTH    = 256;
  localparam int MSG_TAIL_WIDTH    = 96;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } job_state_e;
endpackage

// File: rtl/input_sync.sv
// Multi-stage synchronizer for one asynchronous pin, followed by a single edge register.
module input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      prev_q <= RESET_VALUE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_job_rx.sv
// SPI slave that shifts in one job frame per chip-select low period and offers it
// to the hashing pool through a valid/ready output register.
module spi_job_rx
  import shapool_pkg::*;
#(
  parameter int JOB_WIDTH   = JOB_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 sck_in,
  input  logic                 sdi_in,
  input  logic                 cs_n_in,
  output logic [JOB_WIDTH-1:0] job_data_out,
  output logic                 job_valid_out,
  input  logic                 job_ready_in,
  output logic                 busy_out,
  output logic                 error_out,
  output job_state_e           state_dbg
);
  localparam int             CW         = $clog2(JOB_WIDTH + 2);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(JOB_WIDTH);
  localparam logic [CW-1:0]  COUNT_MAX  = CW'(JOB_WIDTH + 1);

  job_state_e             state, state_next;
  logic [CW-1:0]          count;
  logic [JOB_WIDTH-1:0]   shift_reg;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q;
  logic                   start;

  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_edges;

  input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sck_sync (
    .clk_in(clk_in), .reset_in(reset_in), .async_in(sck_in),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sdi_sync (
    .clk_in(clk_in), .reset_in(reset_in), .async_in(sdi_in),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );
  input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs_sync (
    .clk_in(clk_in), .reset_in(reset_in), .async_in(cs_n_in),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_edges = sck_level ^ sck_fall ^ sdi_rise ^ sdi_fall;

  // The cs synchronizer is preset high, so a reset taken mid-frame would show a
  // false cs_fall once the real low level arrives. Frames are accepted only after
  // the chain has flushed and cs_n has been seen high.
  assign start = (state == IDLE) && cs_fall && armed_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = COMMIT;
      COMMIT:               state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // Handshake: job_data_out is stable while job_valid_out is high; a transfer
  // happens on any cycle with job_valid_out & job_ready_in, and valid drops on
  // the next cycle. A commit tests valid before that cycle's transfer.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      count         <= '0;
      shift_reg     <= '0;
      job_data_out  <= '0;
      job_valid_out <= 1'b0;
      error_out     <= 1'b0;
      flush_q       <= '0;
      armed_q       <= 1'b0;
    end else begin
      state   <= state_next;
      flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      if (flush_q[SYNC_STAGES] && cs_level) armed_q <= 1'b1;
      if (job_valid_out && job_ready_in) job_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count     <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[JOB_WIDTH-2:0], sdi_level};
            if (count != COUNT_MAX) count <= count + 1'b1;
          end
        end
        COMMIT: begin
          if (count == COUNT_FULL && !job_valid_out) begin
            job_data_out  <= shift_reg;
            job_valid_out <= 1'b1;
          end else begin
            error_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out  = (state != IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_spi_job_rx.sv
// Directed bench for spi_job_rx: table of whole-frame vectors plus hand-written
// sequences for mid-frame reset and back-to-back frames with ready held high.
module tb_spi_job_rx;
  import shapool_pkg::*;

  localparam int JW   = JOB_WIDTH_DEFAULT;
  localparam int SYNC = 2;
  localparam int FW   = 360;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_in = 1'b1;
  logic          sck = 1'b0, sdi = 1'b0, cs_n = 1'b1, ready = 1'b0;
  logic [JW-1:0] job_data;
  logic          job_valid, busy, error;
  job_state_e    state_dbg;

  spi_job_rx #(.JOB_WIDTH(JW), .SYNC_STAGES(SYNC)) dut (
    .clk_in(clk), .reset_in(reset_in), .sck_in(sck), .sdi_in(sdi), .cs_n_in(cs_n),
    .job_data_out(job_data), .job_valid_out(job_valid), .job_ready_in(ready),
    .busy_out(busy), .error_out(error), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;
  logic [JW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: every handshake pops one expected frame ----------------
  always @(negedge clk) begin
    if (!reset_in && job_valid && ready) begin
      n_hs++;
      if (exp_q.size() == 0) chk("unexpected_handshake", FW'(1), FW'(0));
      else chk("handshake_data", FW'(job_data), FW'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, FW'(job_valid), FW'(0));
    chk({tag, "_data"},  FW'(job_data),  FW'(0));
    chk({tag, "_busy"},  FW'(busy),      FW'(0));
    chk({tag, "_error"}, FW'(error),     FW'(0));
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    clk_wait(2);
    reset_in = 1'b0;
    check_reset_outputs("reset");
    clk_wait(6);
  endtask

  // Sends bits[nbits-1] first at f_clk/4; pulses reset after abort_at bits if >= 0.
  // Returns right after driving cs_n high (at posedge + 1).
  task automatic send_frame(input logic [FW-1:0] bits, input int nbits, input int abort_at);
    cs_n = 1'b0;
    clk_wait(2);
    for (int i = 0; i < nbits; i++) begin
      sdi = bits[nbits-1-i];
      sck = 1'b0;
      clk_wait(2);
      sck = 1'b1;
      clk_wait(2);
      if (i + 1 == abort_at) begin
        sck = 1'b0;
        reset_in = 1'b1;
        clk_wait(1);
        reset_in = 1'b0;
        check_reset_outputs("midframe_reset");
      end
    end
    sck = 1'b0;
    clk_wait(2);
    cs_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (job_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    ready = 1'b1;
    clk_wait(1);
    ready = 1'b0;
    chk("drain_valid_cleared", FW'(job_valid), FW'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          reset_before;
    int            idle_toggles;
    logic [FW-1:0] bits;
    int            nbits;
    logic          new_commit;
    logic          exp_valid;
    logic [JW-1:0] exp_data;
    logic          exp_error;
    logic          do_drain;
  } vec_t;

  function automatic vec_t mk(input logic rb, input int tog, input logic [FW-1:0] b, input int nb,
                              input logic nc, input logic ev, input logic [JW-1:0] ed,
                              input logic ee, input logic dr);
    vec_t v;
    v.reset_before = rb; v.idle_toggles = tog; v.bits = b; v.nbits = nb;
    v.new_commit = nc; v.exp_valid = ev; v.exp_data = ed; v.exp_error = ee; v.do_drain = dr;
    return v;
  endfunction

  logic [JW-1:0] frame1, ones, frame_c, frame_d, frame_e;
  logic [FW-1:0] odd_bits;
  vec_t vecs[6];

  initial begin
    int lat;
    int hs_before;
    logic busy_seen;

    frame1   = {{8{32'hDEADBEEF}}, 96'h0123456789ABCDEF01234567};
    ones     = '1;
    frame_c  = {11{32'h13579BDF}};
    frame_d  = {11{32'hCAFEF00D}};
    frame_e  = {22{16'h55AA}};
    odd_bits = {45{8'hA5}};

    // reset, idle toggles, bits, nbits, new commit, exp valid, exp data, exp error, drain
    vecs[0] = mk(1'b1, 0,  FW'(frame1),  JW,     1'b1, 1'b1, frame1,  1'b0, 1'b0);
    vecs[1] = mk(1'b0, 0,  FW'(ones),    JW,     1'b0, 1'b1, frame1,  1'b1, 1'b1);
    vecs[2] = mk(1'b1, 0,  odd_bits,     JW - 1, 1'b0, 1'b0, '0,      1'b1, 1'b0);
    vecs[3] = mk(1'b0, 0,  odd_bits,     JW + 1, 1'b0, 1'b0, '0,      1'b1, 1'b0);
    vecs[4] = mk(1'b0, 0,  FW'(frame_c), JW,     1'b1, 1'b1, frame_c, 1'b1, 1'b1);
    vecs[5] = mk(1'b1, 10, FW'(frame_d), JW,     1'b1, 1'b1, frame_d, 1'b0, 1'b1);

    clk_wait(3);
    chk("por_state_idle", FW'(state_dbg), FW'(IDLE));

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].reset_before) do_reset();
      if (vecs[v].idle_toggles > 0) begin
        busy_seen = 1'b0;
        for (int t = 0; t < vecs[v].idle_toggles; t++) begin
          sck = 1'b1; clk_wait(2); busy_seen |= busy;
          sck = 1'b0; clk_wait(2); busy_seen |= busy;
        end
        clk_wait(4);
        chk($sformatf("v%0d_idle_busy_seen", v), FW'(busy_seen), FW'(0));
        chk($sformatf("v%0d_idle_state", v), FW'(state_dbg), FW'(IDLE));
      end
      send_frame(vecs[v].bits, vecs[v].nbits, -1);
      if (vecs[v].new_commit) begin
        exp_q.push_back(vecs[v].exp_data);
        wait_valid(lat);
        chk($sformatf("v%0d_latency", v), FW'(lat), FW'(SYNC + 2));
      end
      clk_wait(6);
      chk($sformatf("v%0d_valid", v), FW'(job_valid), FW'(vecs[v].exp_valid));
      chk($sformatf("v%0d_error", v), FW'(error),     FW'(vecs[v].exp_error));
      chk($sformatf("v%0d_busy", v),  FW'(busy),      FW'(0));
      if (vecs[v].exp_valid)
        chk($sformatf("v%0d_data", v), FW'(job_data), FW'(vecs[v].exp_data));
      if (vecs[v].do_drain) drain();
    end

    // reset after bit 200: rest of the frame must be ignored, next frame accepted
    send_frame(FW'(frame_c), JW, 200);
    clk_wait(8);
    chk("abort_valid", FW'(job_valid), FW'(0));
    chk("abort_error", FW'(error),     FW'(0));
    chk("abort_busy",  FW'(busy),      FW'(0));
    clk_wait(4);
    exp_q.push_back(frame_e);
    send_frame(FW'(frame_e), JW, -1);
    wait_valid(lat);
    chk("after_abort_latency", FW'(lat), FW'(SYNC + 2));
    chk("after_abort_data",    FW'(job_data), FW'(frame_e));
    chk("after_abort_error",   FW'(error),    FW'(0));
    drain();

    // three back-to-back frames with ready held high, cs_n high 4 clk between
    clk_wait(4);
    ready = 1'b1;
    hs_before = n_hs;
    exp_q.push_back(frame1);
    exp_q.push_back(frame_c);
    exp_q.push_back(frame_d);
    send_frame(FW'(frame1), JW, -1);
    clk_wait(4);
    send_frame(FW'(frame_c), JW, -1);
    clk_wait(4);
    send_frame(FW'(frame_d), JW, -1);
    clk_wait(10);
    ready = 1'b0;
    chk("b2b_handshakes", FW'(n_hs - hs_before), FW'(3));
    chk("b2b_error",      FW'(error),     FW'(0));
    chk("b2b_valid",      FW'(job_valid), FW'(0));
    chk("exp_q_empty",    FW'(exp_q.size()), FW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL timeout: got no finish expected finish before 900000 ns");
    $fatal(1, "timeout");
  end
endmodule
